// File: rtl/frodo_mac_sequencer.sv
// Control stage for the Frodo MAC: streams N_LEN operand pairs, chains each MAC result back as in_c.
// Optional macro FRODO_SEQ_QMASK_EN reduces res_data mod 2^LOG_Q; acc itself stays full width.
module frodo_mac_sequencer #(
  parameter int W       = 16,
  parameter int N_LEN   = 8,
  parameter int MAC_LAT = 1,
  parameter int LOG_Q   = 15
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] e_in,
  output logic         busy,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_s,
  output logic         mac_en,
  output logic [W-1:0] mac_a,
  output logic [W-1:0] mac_b,
  output logic [W-1:0] mac_c,
  input  logic [W-1:0] mac_d,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data
);

  localparam int KW = $clog2(N_LEN + 1);
  localparam int CW = $clog2(MAC_LAT + 1);
  localparam logic [KW-1:0] K_LAST = KW'(N_LEN - 1);
  localparam logic [CW-1:0] C_LAST = CW'(MAC_LAT);

`ifdef FRODO_SEQ_QMASK_EN
  localparam logic [W-1:0] RES_MASK = W'((64'd1 << LOG_Q) - 64'd1);
`else
  localparam logic [W-1:0] RES_MASK = '1;
`endif

  if (N_LEN < 1 || MAC_LAT < 1 || LOG_Q < 1 || LOG_Q > W) begin : g_param_check
    $error("frodo_mac_sequencer: illegal parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_RESULT} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [KW-1:0] k_q, k_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          mac_en_q, mac_en_d;
  logic [W-1:0]  mac_a_q, mac_a_d, mac_b_q, mac_b_d, mac_c_q, mac_c_d;
  logic          res_valid_q, res_valid_d;
  logic [W-1:0]  res_data_q, res_data_d;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    k_d         = k_q;
    cnt_d       = cnt_q;
    mac_en_d    = 1'b0;
    mac_a_d     = mac_a_q;
    mac_b_d     = mac_b_q;
    mac_c_d     = mac_c_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = e_in;
          k_d     = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (op_valid) begin
          mac_a_d  = op_a;
          mac_b_d  = op_s;
          mac_c_d  = acc_q;
          mac_en_d = 1'b1;
          cnt_d    = '0;
          state_d  = S_WAIT;
        end
      end
      S_WAIT: begin
        // cnt_q counts WAIT edges; the last one is the capture edge h+1+MAC_LAT
        if (cnt_q == C_LAST) begin
          acc_d   = mac_d;
          k_d     = k_q + KW'(1);
          state_d = (k_q == K_LAST) ? S_RESULT : S_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESULT: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = S_IDLE;
        end else begin
          res_valid_d = 1'b1;
          res_data_d  = acc_q & RES_MASK;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      acc_q       <= '0;
      k_q         <= '0;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_a_q     <= '0;
      mac_b_q     <= '0;
      mac_c_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      k_q         <= k_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      mac_en_q    <= mac_en_d;
      mac_a_q     <= mac_a_d;
      mac_b_q     <= mac_b_d;
      mac_c_q     <= mac_c_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
    end
  end

  assign op_ready  = (state_q == S_FETCH);
  assign busy      = busy_q;
  assign mac_en    = mac_en_q;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_c     = mac_c_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

endmodule

// File: tb/tb_frodo_mac_sequencer.sv
// Self-checking bench for frodo_mac_sequencer with a registered one-cycle MAC model and a dot-product reference.
module tb_frodo_mac_sequencer;
  localparam int W = 16, N_LEN = 4, MAC_LAT = 1, LOG_Q = 15;
`ifdef FRODO_SEQ_QMASK_EN
  localparam logic [W-1:0] TB_MASK = 16'h7FFF;
`else
  localparam logic [W-1:0] TB_MASK = 16'hFFFF;
`endif

  typedef logic [W-1:0] vec_t [N_LEN];

  logic clk = 1'b0, reset = 1'b1, start = 1'b0, op_valid = 1'b0, res_ready = 1'b0;
  logic [W-1:0] e_in = '0, op_a = '0, op_s = '0, mac_d = '0;
  logic busy, op_ready, mac_en, res_valid;
  logic [W-1:0] mac_a, mac_b, mac_c, res_data;

  int checks = 0, failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  frodo_mac_sequencer #(.W(W), .N_LEN(N_LEN), .MAC_LAT(MAC_LAT), .LOG_Q(LOG_Q)) dut (
    .clk(clk), .reset(reset), .start(start), .e_in(e_in), .busy(busy),
    .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_s(op_s),
    .mac_en(mac_en), .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_d(mac_d),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
  );

  // MAC: out_d registered on the en edge; garbage on every other edge
  always @(posedge clk) begin
    if (mac_en) mac_d <= mac_a * mac_b + mac_c;
    else        mac_d <= W'($urandom);
  end

  logic [W-1:0] seen_c[$];
  int en_cnt = 0, first_issue = 0;
  always @(negedge clk) begin
    if (mac_en) begin
      if (en_cnt == 0) first_issue = cyc;
      en_cnt++;
      seen_c.push_back(mac_c);
    end
  end

  function automatic logic [W-1:0] model_dot(input logic [W-1:0] e, input vec_t a, input vec_t s);
    int unsigned sum = e;
    for (int i = 0; i < N_LEN; i++) sum += a[i] * s[i];
    return sum[W-1:0] & TB_MASK;
  endfunction

  function automatic logic [W-1:0] model_partial(input logic [W-1:0] e, input vec_t a, input vec_t s, input int k);
    int unsigned sum = e;
    for (int i = 0; i < k; i++) sum += a[i] * s[i];
    return sum[W-1:0];
  endfunction

  logic [W-1:0] res_got;
  int res_cyc, stall_bad, hold_bad, post_busy, post_valid;
  bit timed_out;

  task automatic do_dot(input logic [W-1:0] e, input vec_t a, input vec_t s, input int stall_after,
                        input int stall_len, input bit rand_valid, input bit poke_busy,
                        input int rr_delay, input bit poke_result);
    int idx = 0, stalled = 0, guard = 0;
    bit cur_stall;
    logic [W-1:0] held;
    seen_c.delete(); en_cnt = 0; stall_bad = 0; hold_bad = 0; timed_out = 0;
    @(negedge clk);
    start = 1'b1; e_in = e; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; e_in = W'($urandom);
    while (idx < N_LEN && guard < 400) begin
      guard++;
      cur_stall = (idx == stall_after && stalled < stall_len);
      if (cur_stall) begin
        op_valid = 1'b0; stalled++;
      end else begin
        op_valid = rand_valid ? ($urandom_range(0, 2) != 0) : 1'b1;
        op_a = a[idx]; op_s = s[idx];
      end
      if (poke_busy) begin start = 1'b1; e_in = 16'h1234; end
      if (op_valid && op_ready) idx++;
      @(negedge clk);
      if ((!op_valid && mac_en) || (cur_stall && !busy)) stall_bad++;
    end
    op_valid = 1'b0; start = 1'b0;
    if (guard >= 400) timed_out = 1'b1;
    guard = 0;
    while (!res_valid && guard < 100) begin @(negedge clk); guard++; end
    if (!res_valid) timed_out = 1'b1;
    res_cyc = cyc; held = res_data;
    for (int i = 0; i < rr_delay; i++) begin
      if (poke_result) begin start = 1'b1; e_in = 16'h1234; end
      @(negedge clk);
      if (!res_valid || res_data !== held || !busy) hold_bad++;
    end
    res_ready = 1'b1;
    if (poke_result) start = 1'b1;
    res_got = res_data;
    @(negedge clk);
    res_ready = 1'b0; start = 1'b0;
    post_busy = busy; post_valid = res_valid;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, op_ready, mac_en, res_valid, mac_a, mac_b, mac_c, res_data} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got busy=%b rdy=%b en=%b rv=%b a=%h b=%h c=%h rd=%h required all 0",
               busy, op_ready, mac_en, res_valid, mac_a, mac_b, mac_c, res_data);
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || op_ready !== 1'b0) begin
      failures++; $display("FAIL idle_after_reset: got busy=%b op_ready=%b required 0 0", busy, op_ready);
    end
  endtask

  task automatic test_basic();
    vec_t a = '{16'd15, 16'd8, 16'd0, 16'd1};
    vec_t s = '{16'd3, 16'd7, 16'd0, 16'd2};
    logic [W-1:0] exp_c;
    do_dot(16'd5, a, s, -1, 0, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (timed_out) begin failures++; $display("FAIL basic_timeout: got timeout required completion"); end
    checks++;
    if (res_got !== model_dot(16'd5, a, s)) begin
      failures++; $display("FAIL basic_res: got %h required %h", res_got, model_dot(16'd5, a, s));
    end
    checks++;
    if (en_cnt != N_LEN) begin failures++; $display("FAIL basic_en_count: got %0d required %0d", en_cnt, N_LEN); end
    for (int i = 0; i < N_LEN && i < seen_c.size(); i++) begin
      exp_c = model_partial(16'd5, a, s, i);
      checks++;
      if (seen_c[i] !== exp_c) begin failures++; $display("FAIL basic_mac_c%0d: got %h required %h", i, seen_c[i], exp_c); end
    end
    checks++;
    if (res_cyc - first_issue != N_LEN * (MAC_LAT + 2)) begin
      failures++; $display("FAIL basic_latency: got %0d required %0d", res_cyc - first_issue, N_LEN * (MAC_LAT + 2));
    end
    checks++;
    if (post_busy !== 0 || post_valid !== 0) begin
      failures++; $display("FAIL basic_idle: got busy=%0d rv=%0d required 0 0", post_busy, post_valid);
    end
    $display("txn basic e=0005 res=%h", res_got);
  endtask

  task automatic test_wrap();
    vec_t a = '{16'hFFFF, 16'd0, 16'd0, 16'd0};
    vec_t s = '{16'd1, 16'd0, 16'd0, 16'd0};
    vec_t z = '{16'd0, 16'd0, 16'd0, 16'd0};
    do_dot(16'h03E8, a, s, -1, 0, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (res_got !== (16'h03E7 & TB_MASK)) begin
      failures++; $display("FAIL wrap_res: got %h required %h", res_got, 16'h03E7 & TB_MASK);
    end
    $display("txn wrap e=03e8 res=%h", res_got);
    do_dot(16'h8000, z, z, -1, 0, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (res_got !== (16'h8000 & TB_MASK)) begin
      failures++; $display("FAIL wrap_msb: got %h required %h", res_got, 16'h8000 & TB_MASK);
    end
    $display("txn wrap e=8000 res=%h", res_got);
  endtask

  task automatic test_stall();
    vec_t a = '{16'd15, 16'd8, 16'd0, 16'd1};
    vec_t s = '{16'd3, 16'd7, 16'd0, 16'd2};
    do_dot(16'd5, a, s, 2, 5, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (stall_bad != 0) begin failures++; $display("FAIL stall_quiet: got %0d bad cycles required 0", stall_bad); end
    checks++;
    if (res_got !== 16'h006C) begin failures++; $display("FAIL stall_res: got %h required 006c", res_got); end
    checks++;
    if (en_cnt != N_LEN) begin failures++; $display("FAIL stall_en_count: got %0d required %0d", en_cnt, N_LEN); end
    $display("txn stall e=0005 res=%h", res_got);
  endtask

  task automatic test_backpressure();
    vec_t a = '{16'd15, 16'd8, 16'd0, 16'd1};
    vec_t s = '{16'd3, 16'd7, 16'd0, 16'd2};
    do_dot(16'd5, a, s, -1, 0, 1'b0, 1'b0, 3, 1'b1);
    checks++;
    if (hold_bad != 0) begin failures++; $display("FAIL bp_hold: got %0d unstable cycles required 0", hold_bad); end
    checks++;
    if (res_got !== 16'h006C) begin failures++; $display("FAIL bp_res: got %h required 006c", res_got); end
    checks++;
    if (post_busy !== 0 || post_valid !== 0) begin
      failures++; $display("FAIL bp_idle: got busy=%0d rv=%0d required 0 0", post_busy, post_valid);
    end
    $display("txn backpressure e=0005 res=%h", res_got);
  endtask

  task automatic test_reset_mid();
    vec_t a = '{16'd15, 16'd8, 16'd0, 16'd1};
    vec_t s = '{16'd3, 16'd7, 16'd0, 16'd2};
    int idx = 0, issues = 0, guard = 0;
    @(negedge clk); start = 1'b1; e_in = 16'd5;
    @(negedge clk); start = 1'b0;
    while (issues < 2 && guard < 100) begin
      guard++;
      op_valid = 1'b1; op_a = a[idx]; op_s = s[idx];
      if (op_ready) idx++;
      @(negedge clk);
      if (mac_en) issues++;
    end
    op_valid = 1'b0;
    checks++;
    if (mac_c !== 16'd50) begin failures++; $display("FAIL mid_second_issue: got mac_c=%h required 0032", mac_c); end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL mid_busy: got %b required 1", busy); end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({busy, op_ready, mac_en, res_valid, mac_a, mac_b, mac_c, res_data} !== '0) begin
      failures++;
      $display("FAIL mid_async_reset: got busy=%b rdy=%b en=%b rv=%b a=%h b=%h c=%h rd=%h required all 0",
               busy, op_ready, mac_en, res_valid, mac_a, mac_b, mac_c, res_data);
    end
    @(negedge clk); reset = 1'b1;
    do_dot(16'd5, a, s, -1, 0, 1'b0, 1'b0, 0, 1'b0);
    checks++;
    if (res_got !== 16'h006C) begin failures++; $display("FAIL mid_restart_res: got %h required 006c", res_got); end
    $display("txn reset_mid restart res=%h", res_got);
  endtask

  task automatic test_start_busy();
    vec_t a = '{16'd15, 16'd8, 16'd0, 16'd1};
    vec_t s = '{16'd3, 16'd7, 16'd0, 16'd2};
    do_dot(16'd5, a, s, -1, 0, 1'b0, 1'b1, 0, 1'b0);
    checks++;
    if (res_got !== 16'h006C) begin failures++; $display("FAIL busy_start_res: got %h required 006c", res_got); end
    checks++;
    if (seen_c.size() < 1 || seen_c[0] !== 16'd5) begin
      failures++; $display("FAIL busy_start_seed: got %h required 0005", seen_c.size() > 0 ? seen_c[0] : 16'hxxxx);
    end
    $display("txn start_busy e=0005 res=%h", res_got);
  endtask

  task automatic test_random();
    vec_t a, s;
    logic [W-1:0] e, exp_r;
    for (int t = 0; t < 20; t++) begin
      e = W'($urandom);
      for (int i = 0; i < N_LEN; i++) begin a[i] = W'($urandom); s[i] = W'($urandom); end
      do_dot(e, a, s, -1, 0, 1'b1, 1'b0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      exp_r = model_dot(e, a, s);
      checks++;
      if (timed_out || res_got !== exp_r) begin
        failures++; $display("FAIL rand%0d_res: got %h timeout=%0d required %h", t, res_got, timed_out, exp_r);
      end
      checks++;
      if (stall_bad != 0 || hold_bad != 0 || en_cnt != N_LEN) begin
        failures++; $display("FAIL rand%0d_protocol: got stall=%0d hold=%0d en=%0d required 0 0 %0d",
                             t, stall_bad, hold_bad, en_cnt, N_LEN);
      end
      for (int i = 0; i < N_LEN && i < seen_c.size(); i++) begin
        checks++;
        if (seen_c[i] !== model_partial(e, a, s, i)) begin
          failures++; $display("FAIL rand%0d_mac_c%0d: got %h required %h", t, i, seen_c[i], model_partial(e, a, s, i));
        end
      end
      $display("txn random %0d e=%h res=%h", t, e, res_got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_stall();
    test_backpressure();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion required finish before 400000");
    $fatal(1, "watchdog expired");
  end

endmodule
